serial_recip_engine: RTL
========================

# serial_recip_engine

Parametrised, nibble-serial fixed-point reciprocal engine for the raycaster datapath. It accepts a signed Q(INT_BITS.FRAC_BITS) operand as a stream of NIB-bit nibbles, most-significant first. It computes 1/x with a sequential restoring divider, one quotient bit per cycle, with optional absolute-value mode and saturation. It streams the result back out MSB-first under a valid/ready handshake. It is the successor to the fixed 16-bit, free-running load/compute/dump reciprocal sequencer: width and nibble size are configurable, and both ports have explicit flow control.

## Interface
- INT_BITS, 6: integer bits, including sign.
- FRAC_BITS, 10: fractional bits. Constraint: FRAC_BITS >= INT_BITS-1.
- NIB, 4: nibble width. W = INT_BITS+FRAC_BITS must be a multiple of NIB.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- i_valid  in  1  input nibble strobe.
- i_data  in  NIB  operand nibble, MSB-first.
- i_abs  in  1  1 = return |1/x|. Sampled with the final operand nibble.
- o_ready  out  1  engine accepts a nibble this cycle.
- o_valid  out  1  o_data holds a result nibble.
- i_ready  in  1  downstream accepts the result nibble.
- o_data  out  NIB  result nibble, MSB-first.
- o_last  out  1  o_data is the final nibble (W/NIB-th).
- o_sat  out  1  current or most recent result saturated.

## Operation
- States: LOAD, DIVIDE, OUT.
- Reset clears all state and enters LOAD with nibble count 0. Reset values: o_valid=0, o_last=0, o_sat=0, o_data=0, o_ready=1.
- LOAD
  - o_ready=1.
  - Each edge with i_valid=1 shifts i_data into the operand register LSB side (operand <= {operand, i_data}) and increments the count.
  - On the W/NIB-th accepted nibble:
    - latch i_abs;
    - compute the magnitude m=|x| in W bits (0x8000 gives 32768);
    - record the sign;
    - enter DIVIDE.
  - i_valid is ignored outside LOAD.
- DIVIDE
  - Exactly W-1 cycles, regardless of operand.
  - Restoring division of 2^(2*FRAC_BITS) by m yields W-1 magnitude bits q, truncated toward zero.
  - Saturation rule: sat = (m <= 2^(2*FRAC_BITS-W+1)), which includes m=0.
  - Result formation:
    - sat and (positive or abs): result = 2^(W-1)-1.
    - sat and negative and !abs: result = -2^(W-1).
    - not sat: result = q when positive or abs, otherwise two's complement -q.
  - The result and o_sat are registered on the final DIVIDE edge, then the block enters OUT.
- OUT
  - o_valid=1 and o_data = result[W-1:W-NIB].
  - Each edge with i_ready=1 shifts the result left by NIB and increments the count.
  - o_last=1 while the final nibble is presented.
  - Acceptance of the final nibble returns the block to LOAD with count 0. o_valid drops the next cycle.
  - While i_ready=0, o_data and o_last hold.
- o_sat holds until the next result is registered or reset.

## Timing
- Load: W/NIB cycles minimum, at one nibble per i_valid edge. Gaps in i_valid are allowed.
- Latency: the final-nibble accept edge is E0. o_valid is first high after edge E0+(W-1), i.e. 15 cycles for W=16.
- Drain: W/NIB cycles when i_ready is held high.
- Next operand: the first nibble of the next operand is accepted no earlier than the cycle after the last output handshake. There is no overlap between LOAD and OUT.
- Reset:
  - Reset in any state (mid-load, mid-divide, or mid-output) discards all work. Outputs take their reset values after that edge.
  - Reset dominates i_valid and i_ready on the same edge.

## Test plan
All cases use the defaults (W=16, Q6.10, NIB=4).
- Basic reciprocals, abs=0:
  - 0x0400 (1.0) -> 0x0400, nibbles 0,4,0,0, o_sat=0.
  - 0x0800 -> 0x0200.
  - 0x0021 -> 0x7C1F, nibbles 7,C,1,F; o_last on F only.
- Sign and abs mode:
  - 0xFC00, abs=0 -> 0xFC00.
  - 0xFC00, abs=1 -> 0x0400.
  - 0x8000, abs=0 -> 0xFFE0.
- Saturation:
  - 0x0000 -> 0x7FFF, o_sat=1.
  - 0x0020 -> 0x7FFF, o_sat=1.
  - 0xFFE0, abs=0 -> 0x8000, o_sat=1.
  - 0xFFE0, abs=1 -> 0x7FFF.
- Latency:
  - Nibbles on consecutive cycles: o_valid rises exactly 15 cycles after the final accept edge.
  - i_valid pulses during DIVIDE or OUT are ignored; the result is unchanged.
- Backpressure: hold i_ready=0 for 3 cycles on each nibble of 0x7C1F -> o_data stable across every stall, 4 handshakes total, then o_ready=1.
- Reset mid-operation:
  - Reset after 2 nibbles, then load 0x0800 -> 0x0200.
  - Reset during DIVIDE or OUT -> o_valid=0 next cycle and o_sat=0.

Source files
------------

// File: rtl/serial_recip_engine.sv
`default_nettype none
// ============================================================================
// Module   : serial_recip_engine
// Purpose  : Nibble-serial signed fixed-point reciprocal. Loads a
//            Q(INT_BITS.FRAC_BITS) operand MSB-first, divides 2^(2*FRAC_BITS)
//            by |x| one quotient bit per cycle with a restoring divider,
//            applies sign/abs/saturation and streams the result MSB-first.
// Revision : 1.0 - initial release
// ============================================================================
module serial_recip_engine #(
    parameter int INT_BITS  = 6,
    parameter int FRAC_BITS = 10,
    parameter int NIB       = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_valid,
    input  logic [NIB-1:0] i_data,
    input  logic           i_abs,
    output logic           o_ready,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [NIB-1:0] o_data,
    output logic           o_last,
    output logic           o_sat
);

    localparam int W       = INT_BITS + FRAC_BITS;
    localparam int NB      = W / NIB;
    localparam int CW      = $clog2(W) + 1;
    localparam int SAT_EXP = 2 * FRAC_BITS - W + 1;

    // The dividend 2^(2*FRAC_BITS) has only zeros below bit SAT_EXP+W-1, so
    // its leading bits are preloaded as the initial partial remainder and the
    // W-1 iterations only ever shift in zeros.  The same value is the
    // saturation threshold: any m at or below it gives a quotient >= 2^(W-1).
    localparam logic [W-1:0]  c_R0       = {{(W-1){1'b0}}, 1'b1} << SAT_EXP;
    localparam logic [CW-1:0] c_NB_LAST  = CW'(NB - 1);
    localparam logic [CW-1:0] c_NB_PEN   = CW'(NB - 2);
    localparam logic [CW-1:0] c_DIV_LAST = CW'(W - 2);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [W-1:0]    r_operand;
    logic [W-1:0]    r_mag;
    logic [W-1:0]    r_rem;
    logic [W-2:0]    r_quo;
    logic            r_neg;
    logic            r_abs;
    logic            r_sat_pend;
    logic [W-1:0]    r_result;
    logic            r_sat;
    logic            r_valid;
    logic            r_last;
    logic            r_ready;

    logic [W-1:0]    w_op_next;
    logic [W-1:0]    w_mag;
    logic [W:0]      w_rem_shift;
    logic            w_ge;
    logic [W-1:0]    w_diff;
    logic [W-1:0]    w_rem_next;
    logic [W-2:0]    w_quo_next;
    logic [W-1:0]    w_q_ext;
    logic            w_flip;
    logic [W-1:0]    w_result;

    // Operand shift path and its magnitude (most negative value maps to 2^(W-1)).
    assign w_op_next = (r_operand << NIB) | W'(i_data);
    assign w_mag     = w_op_next[W-1] ? (~w_op_next + W'(1)) : w_op_next;

    // One restoring-division step; the remainder always stays below m, so the
    // low W bits of the modulo subtraction are exact.
    assign w_rem_shift = {r_rem, 1'b0};
    assign w_ge        = (w_rem_shift >= {1'b0, r_mag});
    assign w_diff      = w_rem_shift[W-1:0] - r_mag;
    assign w_rem_next  = w_ge ? w_diff : w_rem_shift[W-1:0];
    assign w_quo_next  = {r_quo[W-3:0], w_ge};

    // Final result formation from the quotient completed on this cycle.
    assign w_q_ext  = {1'b0, w_quo_next};
    assign w_flip   = r_neg & ~r_abs;
    assign w_result = r_sat_pend
                    ? (w_flip ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                    : (w_flip ? (~w_q_ext + W'(1)) : w_q_ext);

    // Load / divide / output sequencer with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_LOAD;
            r_count    <= '0;
            r_operand  <= '0;
            r_mag      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_neg      <= 1'b0;
            r_abs      <= 1'b0;
            r_sat_pend <= 1'b0;
            r_result   <= '0;
            r_sat      <= 1'b0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (i_valid) begin
                        r_operand <= w_op_next;
                        if (r_count == c_NB_LAST) begin
                            r_abs      <= i_abs;
                            r_mag      <= w_mag;
                            r_neg      <= w_op_next[W-1];
                            r_sat_pend <= (w_mag <= c_R0);
                            r_rem      <= c_R0;
                            r_quo      <= '0;
                            r_count    <= '0;
                            r_ready    <= 1'b0;
                            r_state    <= ST_DIVIDE;
                        end else begin
                            r_count <= r_count + CW'(1);
                        end
                    end
                end

                ST_DIVIDE: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    if (r_count == c_DIV_LAST) begin
                        r_result <= w_result;
                        r_sat    <= r_sat_pend;
                        r_count  <= '0;
                        r_valid  <= 1'b1;
                        r_last   <= (NB == 1);
                        r_state  <= ST_OUT;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end

                ST_OUT: begin
                    if (i_ready) begin
                        if (r_count == c_NB_LAST) begin
                            r_count <= '0;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_ready <= 1'b1;
                            r_state <= ST_LOAD;
                        end else begin
                            r_result <= r_result << NIB;
                            r_last   <= (r_count == c_NB_PEN);
                            r_count  <= r_count + CW'(1);
                        end
                    end
                end

                default: begin
                    r_state <= ST_LOAD;
                    r_count <= '0;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_last  = r_last;
    assign o_sat   = r_sat;
    assign o_data  = r_result[W-1:W-NIB];

endmodule
`default_nettype wire
